// File: rtl/word_chunk_pkg.sv
// Shared types and sizing helpers for the word chunk pusher/gatherer family.
// Length clamp: 0 or out-of-range lengths select a full word.
package word_chunk_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    function automatic int chunks(input int bus_w, input int data_w);
        return bus_w / data_w;
    endfunction

    function automatic int len_w(input int n_chunks);
        return $clog2(n_chunks + 1);
    endfunction

    function automatic int clamp_len(input int len, input int n_chunks);
        return (len == 0 || len > n_chunks) ? n_chunks : len;
    endfunction

endpackage

// File: rtl/word_chunk_pusher.sv
// Bus-word serializer: one BUS_WIDTH word in, L DATA_WIDTH chunks out.
// Optional parity_o output enabled by defining WORD_CHUNK_PARITY_EN.
module word_chunk_pusher
    import word_chunk_pkg::*;
#(
    parameter int BUS_WIDTH  = 32,
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1,
    localparam int CHUNKS    = chunks(BUS_WIDTH, DATA_WIDTH),
    localparam int LEN_W     = len_w(CHUNKS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [BUS_WIDTH-1:0]  data_i,
    input  logic [LEN_W-1:0]      len_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  last_o,
`ifdef WORD_CHUNK_PARITY_EN
    output logic                  parity_o,
`endif
    output logic                  busy_o
);

    state_e                 state_q, state_d;
    logic [BUS_WIDTH-1:0]   shreg_q, shreg_d;
    logic [LEN_W-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  head;
    logic                   xfer;
    logic                   load;
    int                     len_eff;

    // Drop chunks beyond L, then park the first chunk at the output end.
    function automatic logic [BUS_WIDTH-1:0] align(
        input logic [BUS_WIDTH-1:0] w,
        input int                   l
    );
        logic [BUS_WIDTH-1:0] m;
        m = '0;
        for (int k = 0; k < CHUNKS; k++) begin
            if (k < l) begin
                m[k*DATA_WIDTH +: DATA_WIDTH] = w[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (MSB_FIRST) begin
            m = m << ((CHUNKS - l) * DATA_WIDTH);
        end
        return m;
    endfunction

    assign head = MSB_FIRST ? shreg_q[BUS_WIDTH-1 -: DATA_WIDTH]
                            : shreg_q[DATA_WIDTH-1:0];

    assign out_valid_o = (state_q == SHIFT);
    assign busy_o      = out_valid_o;
    assign last_o      = out_valid_o && (cnt_q == LEN_W'(1));
    assign data_o      = out_valid_o ? head : '0;
    assign xfer        = out_valid_o && out_ready_i;
    assign in_ready_o  = rst_ni &&
                         ((state_q == IDLE) || (last_o && out_ready_i));
    assign load        = in_valid_i && in_ready_o;

`ifdef WORD_CHUNK_PARITY_EN
    assign parity_o = ^data_o;
`endif

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        len_eff = clamp_len(int'(len_i), CHUNKS);
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = SHIFT;
                    shreg_d = align(data_i, len_eff);
                    cnt_d   = LEN_W'(len_eff);
                end
            end
            SHIFT: begin
                if (xfer && last_o) begin
                    if (load) begin
                        shreg_d = align(data_i, len_eff);
                        cnt_d   = LEN_W'(len_eff);
                    end else begin
                        state_d = IDLE;
                        shreg_d = '0;
                        cnt_d   = '0;
                    end
                end else if (xfer) begin
                    shreg_d = MSB_FIRST ? (shreg_q << DATA_WIDTH)
                                        : (shreg_q >> DATA_WIDTH);
                    cnt_d   = cnt_q - LEN_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
